midi_rx: RTL and testbench

- MIDI-in receiver: the counterpart of the board's MIDI transmit path. Deserialises the 31250-baud current-loop UART stream (8N1, LSB first) on the clk domain.
- Parses channel-voice messages, including running status, and presents each complete message as a one-cycle strobe with status and data bytes.
- Feeds the controller logic and LEDs; also lets a bench loop the transmitter back into a receiver.

---
 rtl/midi_pkg.sv | 41 ++++
 rtl/midi_uart_rx.sv | 129 ++++++++++++
 rtl/midi_rx.sv | 98 +++++++++
 tb/tb_midi_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI receive types, constants and small decode helpers.
package midi_pkg;

  localparam int CLKS_PER_BIT_100M = 3200;

  localparam logic [3:0] STATUS_NOTE_OFF = 4'h8;
  localparam logic [3:0] STATUS_NOTE_ON  = 4'h9;
  localparam logic [3:0] STATUS_POLY_AT  = 4'hA;
  localparam logic [3:0] STATUS_CC       = 4'hB;
  localparam logic [3:0] STATUS_PROG     = 4'hC;
  localparam logic [3:0] STATUS_CHAN_AT  = 4'hD;
  localparam logic [3:0] STATUS_PITCH    = 4'hE;

  localparam logic [7:0] RT_MIN  = 8'hF8;
  localparam logic [7:0] SYS_MIN = 8'hF0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] data1;
    logic [7:0] data2;
  } midi_msg_t;

  // True for channel-voice status bytes 0x80..0xEF.
  function automatic logic is_channel_status(input logic [7:0] b);
    return (b[7:4] >= STATUS_NOTE_OFF) && (b[7:4] <= STATUS_PITCH);
  endfunction

  // Program change and channel aftertouch carry one data byte, all others two.
  function automatic logic is_one_data(input logic [7:0] status);
    return (status[7:4] == STATUS_PROG) || (status[7:4] == STATUS_CHAN_AT);
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// MIDI UART byte receiver: input synchroniser plus 8N1 deserialiser.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_100M,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_in,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_in;

  uart_rx_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic [7:0]       byte_data_q, byte_data_d;
  logic             frame_err_q, frame_err_d;

  assign s_in = sync_q[SYNC_STAGES-1];

  // Shift the asynchronous line into the clock domain one stage per cycle.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], midi_in};
  end

  // Next-state and strobe logic for the bit-level receive FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    frame_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!s_in) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = s_in ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {s_in, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (s_in) begin
            byte_valid_d = 1'b1;
            byte_data_d  = shift_q;
            state_d      = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (s_in) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; the synchroniser resets high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= '1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/midi_rx.sv
// MIDI-in receiver: UART byte stream parsed into channel-voice messages with running status.
module midi_rx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_100M,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_in,
  output logic       msg_valid,
  output logic [7:0] msg_status,
  output logic [7:0] msg_data1,
  output logic [7:0] msg_data2,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  logic       rs_valid_q, rs_valid_d;
  logic [7:0] rs_q, rs_d;
  logic       idx_q, idx_d;
  logic [7:0] d1_q, d1_d;
  midi_msg_t  msg_q, msg_d;
  logic       msg_valid_q, msg_valid_d;

  midi_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_uart (
    .clk       (clk),
    .rst       (rst),
    .midi_in   (midi_in),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  // Message assembly: real-time bytes are transparent, system bytes cancel running status.
  always_comb begin
    rs_valid_d  = rs_valid_q;
    rs_d        = rs_q;
    idx_d       = idx_q;
    d1_d        = d1_q;
    msg_d       = msg_q;
    msg_valid_d = 1'b0;

    if (frame_err) begin
      idx_d = 1'b0;
    end else if (byte_valid && (byte_data < RT_MIN)) begin
      if (byte_data >= SYS_MIN) begin
        rs_valid_d = 1'b0;
        idx_d      = 1'b0;
      end else if (is_channel_status(byte_data)) begin
        rs_valid_d = 1'b1;
        rs_d       = byte_data;
        idx_d      = 1'b0;
      end else if (rs_valid_q) begin
        if (!idx_q && is_one_data(rs_q)) begin
          msg_d       = '{status: rs_q, data1: byte_data, data2: 8'h00};
          msg_valid_d = 1'b1;
        end else if (!idx_q) begin
          d1_d  = byte_data;
          idx_d = 1'b1;
        end else begin
          msg_d       = '{status: rs_q, data1: d1_q, data2: byte_data};
          msg_valid_d = 1'b1;
          idx_d       = 1'b0;
        end
      end
    end
  end

  // Parser registers; delivered message fields hold until the next strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_valid_q  <= 1'b0;
      rs_q        <= '0;
      idx_q       <= 1'b0;
      d1_q        <= '0;
      msg_q       <= '0;
      msg_valid_q <= 1'b0;
    end else begin
      rs_valid_q  <= rs_valid_d;
      rs_q        <= rs_d;
      idx_q       <= idx_d;
      d1_q        <= d1_d;
      msg_q       <= msg_d;
      msg_valid_q <= msg_valid_d;
    end
  end

  assign msg_valid  = msg_valid_q;
  assign msg_status = msg_q.status;
  assign msg_data1  = msg_q.data1;
  assign msg_data2  = msg_q.data2;

endmodule

// File: tb/tb_midi_rx.sv
// Directed scoreboard bench for midi_rx at a shortened bit period.
module tb_midi_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       midi_in;
  logic       msg_valid;
  logic [7:0] msg_status;
  logic [7:0] msg_data1;
  logic [7:0] msg_data2;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] exp_msg_q[$];
  logic [7:0]  exp_byte_q[$];
  int          exp_ferr = 0;
  logic [23:0] mon_msg_exp;
  logic [7:0]  mon_byte_exp;

  midi_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .midi_in   (midi_in),
    .msg_valid (msg_valid),
    .msg_status(msg_status),
    .msg_data1 (msg_data1),
    .msg_data2 (msg_data2),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  // 100 MHz system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck run still terminates.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired after %0d checks", n_checks);
    $fatal(1, "[TB] watchdog");
  end

  // Scoreboard: every strobe from the DUT must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid) begin
        n_checks++;
        assert (exp_byte_q.size() > 0) else begin
          n_fail++;
          $error("[TB] FAIL byte_unexpected got=%02h expected=none", byte_data);
        end
        if (exp_byte_q.size() > 0) begin
          mon_byte_exp = exp_byte_q.pop_front();
          n_checks++;
          assert (byte_data === mon_byte_exp) else begin
            n_fail++;
            $error("[TB] FAIL byte_data got=%02h expected=%02h", byte_data, mon_byte_exp);
          end
        end
      end
      if (msg_valid) begin
        n_checks++;
        assert (exp_msg_q.size() > 0) else begin
          n_fail++;
          $error("[TB] FAIL msg_unexpected got=%02h %02h %02h expected=none",
                 msg_status, msg_data1, msg_data2);
        end
        if (exp_msg_q.size() > 0) begin
          mon_msg_exp = exp_msg_q.pop_front();
          n_checks++;
          assert ({msg_status, msg_data1, msg_data2} === mon_msg_exp) else begin
            n_fail++;
            $error("[TB] FAIL msg got=%02h %02h %02h expected=%06h",
                   msg_status, msg_data1, msg_data2, mon_msg_exp);
          end
        end
      end
      if (frame_err) begin
        n_checks++;
        assert (exp_ferr > 0) else begin
          n_fail++;
          $error("[TB] FAIL frame_err_unexpected got=1 expected=0");
        end
        if (exp_ferr > 0) exp_ferr--;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkQueues(input string tag);
    checkOutput({tag, "_msgs_pending"}, 32'(exp_msg_q.size()), 32'd0);
    checkOutput({tag, "_bytes_pending"}, 32'(exp_byte_q.size()), 32'd0);
    checkOutput({tag, "_ferr_pending"}, 32'(exp_ferr), 32'd0);
  endtask

  task automatic pushMsg(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
    exp_msg_q.push_back({s, d1, d2});
  endtask

  // One 8N1 frame; a low stop bit may be stretched by extra low bit-times.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_ok, input int low_bits);
    if (stop_ok) exp_byte_q.push_back(b);
    else exp_ferr++;
    midi_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      midi_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    midi_in = stop_ok;
    repeat (CPB * (1 + (stop_ok ? 0 : low_bits))) @(negedge clk);
    midi_in = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_msg_valid"}, 32'(msg_valid), 32'd0);
    checkOutput({tag, "_msg_status"}, 32'(msg_status), 32'd0);
    checkOutput({tag, "_msg_data1"}, 32'(msg_data1), 32'd0);
    checkOutput({tag, "_msg_data2"}, 32'(msg_data2), 32'd0);
    checkOutput({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
    checkOutput({tag, "_byte_data"}, 32'(byte_data), 32'd0);
    checkOutput({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    midi_in = 1'b1;
    repeat (5) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    $display("[TB] stray data byte with no status");
    applyStimulus(8'h10, 1'b1, 0);
    checkQueues("stray");

    $display("[TB] control change B0 2E 7F");
    pushMsg(8'hB0, 8'h2E, 8'h7F);
    applyStimulus(8'hB0, 1'b1, 0);
    applyStimulus(8'h2E, 1'b1, 0);
    applyStimulus(8'h7F, 1'b1, 0);
    checkQueues("cc");

    $display("[TB] running status note-on");
    pushMsg(8'h90, 8'h3C, 8'h64);
    pushMsg(8'h90, 8'h3E, 8'h00);
    applyStimulus(8'h90, 1'b1, 0);
    applyStimulus(8'h3C, 1'b1, 0);
    applyStimulus(8'h64, 1'b1, 0);
    applyStimulus(8'h3E, 1'b1, 0);
    applyStimulus(8'h00, 1'b1, 0);
    checkQueues("running");

    $display("[TB] program change C3 05");
    pushMsg(8'hC3, 8'h05, 8'h00);
    applyStimulus(8'hC3, 1'b1, 0);
    applyStimulus(8'h05, 1'b1, 0);
    checkQueues("prog");

    $display("[TB] real-time byte inside message");
    pushMsg(8'hB0, 8'h2E, 8'h7F);
    applyStimulus(8'hB0, 1'b1, 0);
    applyStimulus(8'h2E, 1'b1, 0);
    applyStimulus(8'hF8, 1'b1, 0);
    applyStimulus(8'h7F, 1'b1, 0);
    checkQueues("realtime");

    $display("[TB] system byte cancels running status");
    applyStimulus(8'hF0, 1'b1, 0);
    applyStimulus(8'h12, 1'b1, 0);
    applyStimulus(8'h34, 1'b1, 0);
    checkQueues("sysex");

    $display("[TB] short low glitch");
    midi_in = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    midi_in = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    checkQueues("glitch");

    $display("[TB] framing error followed by break");
    applyStimulus(8'hB0, 1'b1, 0);
    applyStimulus(8'h2E, 1'b0, 5);
    repeat (12 * CPB) @(negedge clk);
    checkQueues("framing");
    pushMsg(8'hB0, 8'h01, 8'h02);
    applyStimulus(8'hB0, 1'b1, 0);
    applyStimulus(8'h01, 1'b1, 0);
    applyStimulus(8'h02, 1'b1, 0);
    checkQueues("after_break");

    $display("[TB] reset during bit 4 of a frame");
    applyStimulus(8'hB0, 1'b1, 0);
    applyStimulus(8'h11, 1'b1, 0);
    midi_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      midi_in = i[0];
      repeat (CPB) @(negedge clk);
    end
    midi_in = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkResetOutputs("midreset");
    midi_in = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    checkQueues("midreset_idle");
    applyStimulus(8'h22, 1'b1, 0);
    pushMsg(8'hB0, 8'h01, 8'h02);
    applyStimulus(8'hB0, 1'b1, 0);
    applyStimulus(8'h01, 1'b1, 0);
    applyStimulus(8'h02, 1'b1, 0);
    checkQueues("after_reset");

    repeat (4 * CPB) @(negedge clk);
    checkOutput("hold_status", 32'(msg_status), 32'hB0);
    checkOutput("hold_data2", 32'(msg_data2), 32'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
